cond_issue_ctrl: RTL and testbench

//  Issue-stage controller for ARM conditional execution. Owns the NZCV flag register.

---
 rtl/cond_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_cond_issue_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cond_issue_ctrl.sv
// Issue-stage controller for ARM conditional execution: owns NZCV, evaluates condition
// codes, and stalls conditional instructions until in-flight flag writers have retired.
module cond_issue_ctrl #(
    parameter int unsigned MAX_PEND = 3,
    parameter logic [3:0]  FLAG_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_cond,
    input  logic       in_setflags,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_exec,
    output logic       out_setflags,
    input  logic       flush,
    input  logic       flag_wr_en,
    input  logic [3:0] flag_wr_data,
    output logic [3:0] flags,
    output logic       pend_err
);

    localparam int unsigned CW = $clog2(MAX_PEND + 1);
    localparam int unsigned SW = CW + 1;
    localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PEND);

    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    logic [3:0]    r_flags;
    logic [CW-1:0] r_pend_cnt;
    logic          r_out_valid;
    logic          r_out_exec;
    logic          r_out_setflags;
    logic          r_pend_err;

    logic [3:0]    w_eff_flags;
    logic          w_n, w_z, w_c, w_v;
    logic          w_cond_pass;
    logic          w_cond_dep;
    logic          w_hazard;
    logic          w_cap_block;
    logic          w_stage_free;
    logic          w_accept;
    logic          w_inc;
    logic          w_dec_wr;
    logic          w_dec_flush;
    logic [SW-1:0] w_sum;
    logic [SW-1:0] w_dec;
    logic [CW-1:0] w_pend_nxt;

    // A same-cycle ALU flag write is bypassed into condition evaluation.
    assign w_eff_flags = flag_wr_en ? flag_wr_data : r_flags;
    assign w_n = w_eff_flags[0];
    assign w_z = w_eff_flags[1];
    assign w_c = w_eff_flags[2];
    assign w_v = w_eff_flags[3];

    always_comb begin
        w_cond_pass = 1'b0;
        case (in_cond)
            4'b0000: w_cond_pass = w_z;
            4'b0001: w_cond_pass = !w_z;
            4'b0010: w_cond_pass = w_c;
            4'b0011: w_cond_pass = !w_c;
            4'b0100: w_cond_pass = w_n;
            4'b0101: w_cond_pass = !w_n;
            4'b0110: w_cond_pass = w_v;
            4'b0111: w_cond_pass = !w_v;
            4'b1000: w_cond_pass = w_c && !w_z;
            4'b1001: w_cond_pass = !w_c || w_z;
            4'b1010: w_cond_pass = (w_n == w_v);
            4'b1011: w_cond_pass = (w_n != w_v);
            4'b1100: w_cond_pass = !w_z && (w_n == w_v);
            4'b1101: w_cond_pass = w_z || (w_n != w_v);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    // Only a single outstanding writer can be resolved by the bypass path.
    assign w_cond_dep   = (in_cond != COND_AL) && (in_cond != COND_NV);
    assign w_hazard     = w_cond_dep &&
                          ((r_pend_cnt > CW'(1)) || ((r_pend_cnt == CW'(1)) && !flag_wr_en));
    assign w_cap_block  = in_setflags && (r_pend_cnt == PEND_MAX) && !flag_wr_en;
    assign w_stage_free = !r_out_valid || out_ready;
    assign in_ready     = !reset && w_stage_free && !w_hazard && !w_cap_block && !flush;
    assign w_accept     = in_valid && in_ready;

    assign w_inc       = w_accept && in_setflags && w_cond_pass;
    assign w_dec_wr    = flag_wr_en && (r_pend_cnt != '0);
    assign w_dec_flush = flush && r_out_valid && r_out_setflags;

    // All simultaneous count events net in one update, floored at zero.
    assign w_sum = {1'b0, r_pend_cnt} + SW'(w_inc);
    assign w_dec = SW'(w_dec_wr) + SW'(w_dec_flush);
    assign w_pend_nxt = (w_sum < w_dec) ? '0 : CW'(w_sum - w_dec);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags        <= FLAG_RST;
            r_pend_cnt     <= '0;
            r_out_valid    <= 1'b0;
            r_out_exec     <= 1'b0;
            r_out_setflags <= 1'b0;
            r_pend_err     <= 1'b0;
        end else begin
            if (flag_wr_en) begin
                r_flags <= flag_wr_data;
            end
            if (flag_wr_en && (r_pend_cnt == '0)) begin
                r_pend_err <= 1'b1;
            end
            r_pend_cnt <= w_pend_nxt;
            if (flush) begin
                r_out_valid    <= 1'b0;
                r_out_exec     <= 1'b0;
                r_out_setflags <= 1'b0;
            end else if (w_accept) begin
                r_out_valid    <= 1'b1;
                r_out_exec     <= w_cond_pass;
                r_out_setflags <= in_setflags && w_cond_pass;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_exec     = r_out_exec;
    assign out_setflags = r_out_setflags;
    assign flags        = r_flags;
    assign pend_err     = r_pend_err;

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Self-checking bench for cond_issue_ctrl: directed scenarios plus random traffic
// compared against a behavioural model of the issue rules.
module tb_cond_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_cond;
    logic       in_setflags;
    logic       out_valid;
    logic       out_ready;
    logic       out_exec;
    logic       out_setflags;
    logic       flush;
    logic       flag_wr_en;
    logic [3:0] flag_wr_data;
    logic [3:0] flags;
    logic       pend_err;

    cond_issue_ctrl #(.MAX_PEND(3), .FLAG_RST(4'b0000)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond), .in_setflags(in_setflags),
        .out_valid(out_valid), .out_ready(out_ready), .out_exec(out_exec),
        .out_setflags(out_setflags), .flush(flush), .flag_wr_en(flag_wr_en),
        .flag_wr_data(flag_wr_data), .flags(flags), .pend_err(pend_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [3:0] m_flags;
    int         m_cnt;
    bit         m_ov, m_ex, m_sf, m_err;

    localparam logic [3:0] EQ = 4'h0, NE = 4'h1, GT = 4'hC, AL = 4'hE, NV = 4'hF;
    localparam logic [3:0] FZ = 4'b0010;

    // Even codes test a predicate, odd codes its inverse; AL/NV are fixed.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[0]; z = f[1]; cf = f[2]; v = f[3];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c == AL) return 1'b1;
        if (c == NV) return 1'b0;
        return base ^ c[0];
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flags = 4'b0000; m_cnt = 0; m_ov = 0; m_ex = 0; m_sf = 0; m_err = 0;
    endtask

    // One clock: drive at negedge, check in_ready, advance model, check registered outputs.
    task automatic cyc(input bit v, input logic [3:0] c, input bit sf, input bit ordy,
                       input bit fl, input bit we, input logic [3:0] wd, output bit rdy);
        logic [3:0] eff;
        bit pass, hz, cap, free, exp_rdy, acc;
        int nc;
        in_valid = v; in_cond = c; in_setflags = sf; out_ready = ordy;
        flush = fl; flag_wr_en = we; flag_wr_data = wd;
        #1;
        eff     = we ? wd : m_flags;
        pass    = cond_ok(c, eff);
        hz      = (c < 4'd14) && (m_cnt > 1 || (m_cnt == 1 && !we));
        cap     = sf && m_cnt == 3 && !we;
        free    = !m_ov || ordy;
        exp_rdy = free && !hz && !cap && !fl;
        acc     = v && exp_rdy;
        rdy     = in_ready;
        chk("in_ready", 4'(in_ready), 4'(exp_rdy));
        nc = m_cnt + ((acc && sf && pass) ? 1 : 0) - ((we && m_cnt > 0) ? 1 : 0)
                   - ((fl && m_ov && m_sf) ? 1 : 0);
        if (nc < 0) nc = 0;
        if (we && m_cnt == 0) m_err = 1;
        m_cnt = nc;
        if (we) m_flags = wd;
        if (fl) m_ov = 0;
        else if (acc) begin m_ov = 1; m_ex = pass; m_sf = sf && pass; end
        else if (ordy) m_ov = 0;
        @(posedge clk);
        #1;
        chk("out_valid", 4'(out_valid), 4'(m_ov));
        chk("flags", flags, m_flags);
        chk("pend_err", 4'(pend_err), 4'(m_err));
        if (m_ov) begin
            chk("out_exec", 4'(out_exec), 4'(m_ex));
            chk("out_setflags", 4'(out_setflags), 4'(m_sf));
        end
        @(negedge clk);
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit r;
        reset = 1'b1; in_valid = 0; in_cond = 0; in_setflags = 0; out_ready = 0;
        flush = 0; flag_wr_en = 0; flag_wr_data = 0;
        model_reset();
        #2;
        chk("rst_out_valid", 4'(out_valid), 4'h0);
        chk("rst_out_exec", 4'(out_exec), 4'h0);
        chk("rst_out_setflags", 4'(out_setflags), 4'h0);
        chk("rst_flags", flags, 4'h0);
        chk("rst_pend_err", 4'(pend_err), 4'h0);
        chk("rst_in_ready", 4'(in_ready), 4'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Flushed setflags entry releases its pending slot; a later write is an error
        cyc(1, AL, 1, 0, 0, 0, 4'h0, r);
        chk("t5_osf", 4'(out_setflags), 4'h1);
        cyc(0, EQ, 0, 0, 1, 0, 4'h0, r);
        chk("t5_flushed", 4'(out_valid), 4'h0);
        chk("t5_err_before", 4'(pend_err), 4'h0);
        cyc(0, EQ, 0, 1, 0, 1, FZ, r);
        chk("t5_err_after", 4'(pend_err), 4'h1);
        cyc(1, EQ, 0, 1, 0, 0, 4'h0, r);
        chk("t5_cnt_zero", 4'(r), 4'h1);
        sync_reset();
        chk("t5_err_cleared", 4'(pend_err), 4'h0);

        // ADDS then BEQ: stall until the flag write, then bypass
        cyc(1, AL, 1, 1, 0, 0, 4'h0, r);
        cyc(1, EQ, 0, 1, 0, 0, 4'h0, r);
        chk("t2_beq_stall", 4'(r), 4'h0);
        cyc(1, EQ, 0, 1, 0, 1, FZ, r);
        chk("t2_beq_bypass", 4'(r), 4'h1);
        chk("t2_beq_exec", 4'(out_exec), 4'h1);

        // Flags = Z: EQ executes, NE does not
        cyc(1, EQ, 0, 1, 0, 0, 4'h0, r);
        chk("t1_eq_exec", 4'(out_exec), 4'h1);
        cyc(1, NE, 0, 1, 0, 0, 4'h0, r);
        chk("t1_ne_ready", 4'(r), 4'h1);
        chk("t1_ne_exec", 4'(out_exec), 4'h0);
        cyc(0, EQ, 0, 1, 0, 0, 4'h0, r);

        // Capacity limit of three in-flight flag setters
        for (int i = 0; i < 3; i++) begin
            cyc(1, AL, 1, 1, 0, 0, 4'h0, r);
            chk("t3_fill", 4'(r), 4'h1);
        end
        cyc(1, AL, 1, 1, 0, 0, 4'h0, r);
        chk("t3_full_stall", 4'(r), 4'h0);
        cyc(1, AL, 1, 1, 0, 1, 4'h0, r);
        chk("t3_write_admits", 4'(r), 4'h1);
        cyc(1, AL, 1, 1, 0, 0, 4'h0, r);
        chk("t3_still_full", 4'(r), 4'h0);
        for (int i = 0; i < 3; i++) cyc(0, AL, 0, 1, 0, 1, 4'h0, r);
        chk("t3_no_err", 4'(pend_err), 4'h0);

        // Backpressure holds a GT entry while flags change underneath
        cyc(1, GT, 0, 0, 0, 0, 4'h0, r);
        chk("t4_gt_exec", 4'(out_exec), 4'h1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, AL, 0, 0, 0, 1, FZ, r);
            chk("t4_blocked", 4'(r), 4'h0);
            chk("t4_exec_held", 4'(out_exec), 4'h1);
        end
        cyc(0, AL, 0, 1, 0, 0, 4'h0, r);

        // Every condition against every flag value
        for (int f = 0; f < 16; f++) begin
            cyc(0, AL, 0, 1, 0, 1, 4'(f), r);
            for (int c = 0; c < 16; c++) begin
                cyc(1, 4'(c), 0, 1, 0, 0, 4'h0, r);
                if (c == 15) chk("t6_nv_never", 4'(out_exec), 4'h0);
            end
        end

        // Asynchronous reset while stalled
        cyc(1, AL, 1, 0, 0, 0, 4'h0, r);
        cyc(1, AL, 0, 0, 0, 1, 4'h5, r);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_out_valid", 4'(out_valid), 4'h0);
        chk("t6_rst_out_exec", 4'(out_exec), 4'h0);
        chk("t6_rst_out_setflags", 4'(out_setflags), 4'h0);
        chk("t6_rst_flags", flags, 4'h0);
        chk("t6_rst_pend_err", 4'(pend_err), 4'h0);
        chk("t6_rst_in_ready", 4'(in_ready), 4'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit v, sf, ordy, fl, we;
            v    = ($urandom_range(0, 3) != 0);
            sf   = ($urandom_range(0, 1) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            we   = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 31) == 0);
            cyc(v, 4'($urandom_range(0, 15)), sf, ordy, fl, we, 4'($urandom_range(0, 15)), r);
            if (i % 500 == 499) sync_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
